// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor: one full-subtractor cell and a registered borrow
// process one bit per clock, LSB first. It computes
// o_diff = i_minuend - i_subtrahend - i_bin modulo 2^WIDTH and returns the
// borrow out of the MSB.
//
// Parameters:
//   WIDTH         operand/result width in bits (>= 1)
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst         synchronous active-high reset
//   i_valid       operands valid
//   o_ready       block can accept operands (IDLE and not in reset)
//   i_minuend     operand A
//   i_subtrahend  operand B
//   i_bin         borrow-in
//   o_valid       result valid (DONE)
//   i_ready       downstream accepts the result
//   o_diff        A - B - bin, modulo 2^WIDTH
//   o_borrow      borrow out of the MSB
//   o_busy        high in SHIFT or DONE
//   o_overflow    two's-complement overflow flag (only with the macro below)
//
// Optional feature macro: SERIAL_SUBTRACTOR_OVERFLOW_EN adds o_overflow.
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    input  logic             i_bin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    output logic             o_overflow,
`endif
    output logic             o_busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic               ovf_q, ovf_d;
`endif

    // Full-subtractor cell on the current LSBs
    logic               bit_a, bit_b, d_bit, br_nxt;
    logic [WIDTH-1:0]   res_shift;

    always_comb begin
        bit_a     = a_q[0];
        bit_b     = b_q[0];
        d_bit     = bit_a ^ bit_b ^ br_q;
        br_nxt    = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
        // New bit enters at the MSB so the result is LSB-aligned after WIDTH shifts
        res_shift = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    a_d     = i_minuend;
                    b_d     = i_subtrahend;
                    br_d    = i_bin;
                    res_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift;
                br_d  = br_nxt;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    diff_d   = res_shift;
                    borrow_d = br_nxt;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                    // Borrow into MSB vs borrow out of MSB
                    ovf_d    = br_q ^ br_nxt;
`endif
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Status outputs decode the state register; o_ready is also masked by reset
    assign o_ready  = (state_q == ST_IDLE) & ~i_rst;
    assign o_valid  = (state_q == ST_DONE);
    assign o_busy   = (state_q != ST_IDLE);
    assign o_diff   = diff_q;
    assign o_borrow = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Directed scoreboard bench for serial_subtractor (WIDTH=8): expected results
// are queued at issue time and a negedge monitor pops and compares them on
// every result handshake.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_minuend;
    logic [W-1:0] i_subtrahend;
    logic         i_bin;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_diff;
    logic         o_borrow;
    logic         o_busy;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic         o_overflow;
`endif

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } vec_t;

    exp_t sb[$];
    int   tests  = 0;
    int   errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_minuend    (i_minuend),
        .i_subtrahend (i_subtrahend),
        .i_bin        (i_bin),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_diff       (o_diff),
        .o_borrow     (o_borrow),
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        .o_overflow   (o_overflow),
`endif
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for o_ready, then presents one operand set for one cycle
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int n = 0;
        while (!o_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_ready", 32'(o_ready), 32'd1);
        i_minuend    = a;
        i_subtrahend = b;
        i_bin        = bin;
        i_valid      = 1'b1;
        tick();
        i_valid      = 1'b0;
    endtask

    // Result monitor: compares on every accepted result
    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(o_diff), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("diff", 32'(o_diff), 32'(e.diff));
                check("borrow", 32'(o_borrow), 32'(e.borrow));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                check("overflow", 32'(o_overflow), 32'(e.ovf));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   n;
        int   nacc;
        int   acc[2];
        logic accepted;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, bin: 1'b0, diff: 8'h1E, borrow: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, diff: 8'hFF, borrow: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, diff: 8'h00, borrow: 1'b0, ovf: 1'b0};
        vecs[3] = '{a: 8'h80, b: 8'h01, bin: 1'b0, diff: 8'h7F, borrow: 1'b0, ovf: 1'b1};

        // Reset, with i_valid asserted alongside it (must not capture)
        rst          = 1'b1;
        i_valid      = 1'b1;
        i_minuend    = 8'hAA;
        i_subtrahend = 8'h55;
        i_bin        = 1'b0;
        i_ready      = 1'b1;
        repeat (3) tick();
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_diff", 32'(o_diff), 32'd0);
        check("rst_borrow", 32'(o_borrow), 32'd0);
        rst     = 1'b0;
        i_valid = 1'b0;
        tick();
        check("rst_release_ready", 32'(o_ready), 32'd1);
        check("rst_no_capture", 32'(o_busy), 32'd0);

        // Directed vectors with exact latency: o_valid in cycle 9
        for (int v = 0; v < 4; v++) begin
            sb.push_back('{diff: vecs[v].diff, borrow: vecs[v].borrow, ovf: vecs[v].ovf});
            send(vecs[v].a, vecs[v].b, vecs[v].bin);
            for (int k = 1; k <= 8; k++) begin
                check("lat_wait", 32'(o_valid), 32'd0);
                tick();
            end
            check("lat_valid", 32'(o_valid), 32'd1);
            tick();
        end

        // Backpressure: hold the result for 5 cycles, ignore a new request
        i_ready = 1'b0;
        sb.push_back('{diff: 8'h22, borrow: 1'b0, ovf: 1'b0});
        send(8'h33, 8'h11, 1'b0);
        n = 0;
        while (!o_valid && n < 20) begin
            tick();
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(o_valid), 32'd1);
            check("bp_diff", 32'(o_diff), 32'h22);
            check("bp_borrow", 32'(o_borrow), 32'd0);
            check("bp_ready", 32'(o_ready), 32'd0);
            if (k == 1) begin
                i_minuend    = 8'hFF;
                i_subtrahend = 8'h00;
                i_valid      = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(o_valid), 32'd0);
        check("bp_release_ready", 32'(o_ready), 32'd1);

        // Reset in cycle 4 of an operation; the result is discarded
        send(8'hAA, 8'h55, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_diff", 32'(o_diff), 32'd0);
        rst = 1'b0;
        tick();
        check("mid_rst_ready", 32'(o_ready), 32'd1);
        sb.push_back('{diff: 8'hFE, borrow: 1'b1, ovf: 1'b0});
        send(8'h03, 8'h05, 1'b0);
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        check("mid_rst_done", 32'(sb.size()), 32'd0);
        tick();

        // Back-to-back with i_valid held: accepts 10 cycles apart
        sb.push_back('{diff: 8'h80, borrow: 1'b1, ovf: 1'b1});
        sb.push_back('{diff: 8'h63, borrow: 1'b0, ovf: 1'b1});
        i_minuend    = 8'h7F;
        i_subtrahend = 8'hFF;
        i_bin        = 1'b0;
        i_valid      = 1'b1;
        nacc         = 0;
        acc[0]       = 0;
        acc[1]       = 0;
        for (int cyc = 0; cyc < 40 && nacc < 2; cyc++) begin
            accepted = o_ready;
            if (accepted) begin
                acc[nacc] = cyc;
                nacc++;
            end
            tick();
            if (accepted) begin
                if (nacc == 1) begin
                    i_minuend    = 8'hC8;
                    i_subtrahend = 8'h64;
                    i_bin        = 1'b1;
                end else begin
                    i_valid = 1'b0;
                end
            end
        end
        i_valid = 1'b0;
        check("b2b_accepts", 32'(nacc), 32'd2);
        check("b2b_spacing", 32'(acc[1] - acc[0]), 32'd10);
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor: one full-subtractor cell plus a registered borrow, one bit per clock, LSB first.
- Computes o_diff = i_minuend - i_subtrahend - i_bin over WIDTH bits and returns the final borrow.
- Takes operands through a valid/ready handshake and returns the result through a valid/ready handshake.
- It is the inverse counterpart of the team's ripple-adder datapath cells, for area-constrained paths where WIDTH-cycle latency is acceptable.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 and up.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  reset, synchronous and active-high.
- i_valid  input  1  operands valid.
- o_ready  output  1  block can accept operands.
- i_minuend  input  WIDTH  operand A.
- i_subtrahend  input  WIDTH  operand B.
- i_bin  input  1  borrow-in.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_diff  output  WIDTH  A - B - bin, modulo 2^WIDTH.
- o_borrow  output  1  borrow out of the MSB; 1 when the unsigned result is below zero.
- o_busy  output  1  high in SHIFT or DONE.

Behaviour:
- One clock (i_clk). Reset is synchronous and active-high (i_rst).
- States:
  - IDLE: o_ready = 1 and ~i_rst. On i_valid & o_ready, capture A, B and bin into shift/borrow registers, load the bit counter with WIDTH, go to SHIFT.
  - SHIFT: each cycle, with a = A[0], b = B[0], br = borrow register:
    - d = a^b^br
    - br_next = (~a & b) | (~(a^b) & br)
    - Shift A and B right by one; shift d into the result register MSB (after WIDTH cycles the result is LSB-aligned).
    - Decrement the counter. On the cycle the counter reaches 0, load o_diff and o_borrow from the final values and go to DONE.
  - DONE: o_valid = 1; o_diff and o_borrow held stable. On i_ready, go to IDLE.
- Latency: handshake in cycle 0 -> SHIFT in cycles 1..WIDTH -> o_valid high in cycle WIDTH+1.
  - Minimum initiation interval is WIDTH+2 cycles.
  - o_ready does not depend combinationally on i_ready.
- i_valid is ignored outside IDLE. Operand inputs are not sampled after the capture cycle.
- o_diff and o_borrow keep the last result until the next DONE entry. They are not disturbed during SHIFT.
- The counter is sized to $clog2(WIDTH+1) bits. WIDTH=1 takes exactly one SHIFT cycle.
- Reset values, applied at the clock edge where i_rst = 1, from any state including mid-SHIFT:
  - State IDLE; o_valid = 0; o_diff = 0; o_borrow = 0; o_busy = 0; counter and internal registers = 0.
  - An in-flight operation is discarded and never presented.
  - o_ready is forced to 0 while i_rst = 1 and is 1 in the first cycle after deassertion.
- If i_valid and i_rst are high in the same cycle, no capture occurs.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVERFLOW_EN.
- Defined: adds output o_overflow (1 bit), the two's-complement overflow flag.
  - o_overflow = borrow into MSB XOR borrow out of MSB, recorded during the last SHIFT cycle.
  - Loaded with o_diff, held with it, reset to 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan (WIDTH=8):
- Basic timing: A=0x5A, B=0x3C, bin=0, handshake in cycle 0 -> o_valid rises in cycle 9, o_diff=0x1E, o_borrow=0, o_overflow=0.
- Unsigned underflow and borrow-in:
  - A=0x00, B=0x01, bin=0 -> o_diff=0xFF, o_borrow=1, o_overflow=0.
  - A=0x10, B=0x0F, bin=1 -> o_diff=0x00, o_borrow=0.
- Signed overflow: A=0x80, B=0x01, bin=0 -> o_diff=0x7F, o_borrow=0, o_overflow=1.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid.
  - o_valid stays 1; o_diff/o_borrow stable; o_ready=0.
  - A new i_valid pulse during this time is ignored.
  - i_ready=1 -> o_valid=0 and o_ready=1 next cycle.
- Reset mid-SHIFT: assert i_rst in cycle 4 of an operation.
  - Next cycle: o_valid=0, o_busy=0, o_diff=0.
  - o_ready=1 one cycle after deassertion.
  - A following A=0x03, B=0x05 yields o_diff=0xFE, o_borrow=1.
- Back-to-back: i_ready tied 1, i_valid held with two queued operand pairs -> accepts are 10 cycles apart, results in order and correct.
